data_mem_responder: RTL

//   Data-memory responder at the far end of the MEM-stage load/store interface.

---
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: far-end data memory for the MEM-stage load/store port.
// Accepts one word-aligned request at a time, applies a fixed wait-state
// delay, then reports load data or an error with a one-cycle rsp_valid pulse.
// Byte/half extraction and sign extension are left to the requester.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk_i_DMEM,
  input  logic              rst_i_DMEM,
  input  logic              req_valid_i_DMEM,
  input  logic              req_we_i_DMEM,
  input  logic [ADDR_W-1:0] req_addr_i_DMEM,
  input  logic [3:0]        req_be_i_DMEM,
  input  logic [31:0]       req_wdata_i_DMEM,
  output logic              req_ready_o_DMEM,
  output logic              rsp_valid_o_DMEM,
  output logic [31:0]       rsp_rdata_o_DMEM,
  output logic              rsp_err_o_DMEM
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W   = 4;
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0]  CNT_LOAD = NO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic                w_ready;
  logic                w_accept;
  logic                w_enter_resp;
  logic                w_eff_we;
  logic [ADDR_W-1:0]   w_eff_addr;
  logic [3:0]          w_eff_be;
  logic [31:0]         w_eff_wdata;
  logic                w_err;
  logic [IDX_W-1:0]    w_idx;

  // Ready depends only on state and reset so the requester never sees a loop.
  assign w_ready  = (r_state == S_IDLE) && !rst_i_DMEM;
  assign w_accept = req_valid_i_DMEM && w_ready;

  // With no wait states RESP is entered on the acceptance edge itself, so the
  // live request is used there; otherwise the latched copy is used.
  assign w_eff_we    = (r_state == S_IDLE) ? req_we_i_DMEM    : r_we;
  assign w_eff_addr  = (r_state == S_IDLE) ? req_addr_i_DMEM  : r_addr;
  assign w_eff_be    = (r_state == S_IDLE) ? req_be_i_DMEM    : r_be;
  assign w_eff_wdata = (r_state == S_IDLE) ? req_wdata_i_DMEM : r_wdata;

  assign w_enter_resp = !rst_i_DMEM &&
                        (((r_state == S_IDLE) && w_accept && NO_WAIT) ||
                         ((r_state == S_WAIT) && (r_cnt == '0)));

  // Full-width range compare: high address bits must not alias low words.
  assign w_err = (w_eff_addr[1:0] != 2'b00) || ((w_eff_addr >> 2) >= DEPTH_A);
  assign w_idx = w_eff_addr[IDX_W+1:2];

  // Byte-enabled RAM write on the edge entering RESP; contents survive reset.
  always_ff @(posedge clk_i_DMEM) begin
    if (w_enter_resp && w_eff_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_eff_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_eff_wdata[8*b +: 8];
        end
      end
    end
  end

  // Request FSM, wait counter, request latch and registered response.
  always_ff @(posedge clk_i_DMEM) begin
    if (rst_i_DMEM) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we_i_DMEM;
            r_addr  <= req_addr_i_DMEM;
            r_be    <= req_be_i_DMEM;
            r_wdata <= req_wdata_i_DMEM;
            if (NO_WAIT) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (w_enter_resp) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (!w_eff_we && !w_err) ? r_mem[w_idx] : 32'h0;
      end
    end
  end

  assign req_ready_o_DMEM = w_ready;
  assign rsp_valid_o_DMEM = r_rsp_valid;
  assign rsp_rdata_o_DMEM = r_rsp_rdata;
  assign rsp_err_o_DMEM   = r_rsp_err;

endmodule
